// File: rtl/vga_pkg.sv
// vga_pkg: shared command encoding and text-buffer dimensions for the character buffer.
package vga_pkg;
   typedef enum logic [1:0] {CMD_PUT, CMD_NEWLINE, CMD_SET_CURSOR, CMD_CLEAR} cmd_op_t;
   typedef enum logic {ST_IDLE, ST_CLEAR} cb_state_t;
   localparam int CHAR_CODE_WIDTH = 7;
   localparam int TEXT_ROWS = 16;
endpackage

// File: rtl/char_buf_ram.sv
// char_buf_ram: 256x7 text storage, one synchronous write port, registered read-first read port.
module char_buf_ram
   import vga_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [7:0]                 waddr,
   input  logic [CHAR_CODE_WIDTH-1:0] wdata,
   input  logic [7:0]                 raddr,
   output logic [CHAR_CODE_WIDTH-1:0] rdata
);
   logic [CHAR_CODE_WIDTH-1:0] mem [256];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= rst ? '0 : mem[raddr];
   end
endmodule

// File: rtl/char_buf_writer.sv
// char_buf_writer: command-driven text buffer writer with cursor and 256-cycle CLEAR sweep.
// Optional CHAR_BUF_CLEAR_ON_RESET_EN: run a full CLEAR sweep right after reset.
module char_buf_writer
   import vga_pkg::*;
#(
   parameter logic [CHAR_CODE_WIDTH-1:0] BLANK_CHAR = 7'h20,
   parameter int                         COLS       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [7:0]                 cmd_data,
   input  logic [7:0]                 char_xy,
   output logic [CHAR_CODE_WIDTH-1:0] char_code,
   output logic [7:0]                 cursor_xy,
   output logic                       busy
);
   localparam logic [4:0] COL_LAST = 5'(COLS - 1);
   cb_state_t state, state_n;
   logic [7:0] cursor, cursor_n, sweep, sweep_n, waddr;
   logic [3:0] row, col;
   logic [CHAR_CODE_WIDTH-1:0] wdata;
   logic we, init_pend;
`ifdef CHAR_BUF_CLEAR_ON_RESET_EN
   always_ff @(posedge clk) init_pend <= rst;
`else
   assign init_pend = 1'b0;
`endif
   assign row       = cursor[7:4];
   assign col       = cursor[3:0];
   assign cursor_xy = cursor;
   assign busy      = state == ST_CLEAR;
   assign cmd_ready = state == ST_IDLE && !init_pend;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cursor <= '0;
         sweep  <= '0;
      end else begin
         state  <= state_n;
         cursor <= cursor_n;
         sweep  <= sweep_n;
      end
   end
   always_comb begin
      state_n  = state;
      cursor_n = cursor;
      sweep_n  = sweep;
      we       = 1'b0;
      waddr    = cursor;
      wdata    = cmd_data[CHAR_CODE_WIDTH-1:0];
      if (state == ST_CLEAR) begin
         we      = 1'b1;
         waddr   = sweep;
         wdata   = BLANK_CHAR;
         sweep_n = sweep + 8'd1;
         state_n = sweep == 8'hFF ? ST_IDLE : ST_CLEAR;
      end else if (init_pend) begin
         state_n = ST_CLEAR;
         sweep_n = '0;
      end else if (cmd_valid) begin
         case (cmd_op_t'(cmd_op))
            CMD_PUT: begin
               we       = {1'b0, col} <= COL_LAST;
               cursor_n = {1'b0, col} == COL_LAST ? {row + 4'd1, 4'd0} : {row, col + 4'd1};
            end
            CMD_NEWLINE:    cursor_n = {row + 4'd1, 4'd0};
            CMD_SET_CURSOR: cursor_n = {cmd_data[7:4], {1'b0, cmd_data[3:0]} > COL_LAST ? COL_LAST[3:0] : cmd_data[3:0]};
            default: begin
               cursor_n = '0;
               sweep_n  = '0;
               state_n  = ST_CLEAR;
            end
         endcase
      end
      if (rst) we = 1'b0;
   end
   char_buf_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (char_xy),
      .rdata (char_code)
   );
endmodule

// File: tb/tb_char_buf_writer.sv
// tb_char_buf_writer: table vectors, directed corner sequences and random commands against a reference model.
module tb_char_buf_writer;
   import vga_pkg::*;
   localparam int COLS = 16;
   localparam logic [6:0] BLANK = 7'h20;
   logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, busy;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_data = 8'd0, char_xy = 8'd0, cursor_xy;
   logic [6:0] char_code;
   int checks = 0, failures = 0;
   logic [6:0] m_mem [256];
   bit m_known [256];
   int m_row = 0, m_col = 0, m_clr = 0;
   bit e_known, last_busy, last_acc;
   logic [6:0] e_code;
   typedef struct {logic [1:0] op; logic [7:0] data; logic [7:0] exp_cur;} vec_t;
   vec_t tbl [11];

   char_buf_writer #(.BLANK_CHAR(BLANK), .COLS(COLS)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .char_xy(char_xy), .char_code(char_code), .cursor_xy(cursor_xy), .busy(busy)
   );
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      int a;
      @(negedge clk);
      chk("busy", int'(busy), int'(m_clr > 0));
      chk("cmd_ready", int'(cmd_ready), int'(m_clr == 0));
      last_busy = m_clr > 0;
      last_acc  = 1'b0;
      e_known   = m_known[char_xy];
      e_code    = m_mem[char_xy];
      if (m_clr > 0) begin
         a = 256 - m_clr;
         m_mem[a] = BLANK;
         m_known[a] = 1'b1;
         m_clr--;
      end else if (cmd_valid) begin
         last_acc = 1'b1;
         case (cmd_op)
            CMD_PUT: begin
               a = m_row * 16 + m_col;
               m_mem[a] = cmd_data[6:0];
               m_known[a] = 1'b1;
               if (m_col == COLS - 1) begin
                  m_col = 0;
                  m_row = (m_row + 1) % 16;
               end else m_col++;
            end
            CMD_NEWLINE: begin
               m_col = 0;
               m_row = (m_row + 1) % 16;
            end
            CMD_SET_CURSOR: begin
               m_row = int'(cmd_data[7:4]);
               m_col = int'(cmd_data[3:0]) > COLS - 1 ? COLS - 1 : int'(cmd_data[3:0]);
            end
            default: begin
               m_row = 0;
               m_col = 0;
               m_clr = 256;
            end
         endcase
      end
      @(posedge clk);
      #1;
      chk("cursor_xy", int'(cursor_xy), m_row * 16 + m_col);
      if (e_known) chk("char_code", int'(char_code), int'(e_code));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_row = 0;
      m_col = 0;
      m_clr = 0;
      chk("rst_char_code", int'(char_code), 0);
      chk("rst_cursor", int'(cursor_xy), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 1);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] data);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_data = data;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 400);
      if (!last_acc) chk("cmd_timeout", n, 0);
      cmd_valid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [6:0] exp);
      cmd_valid = 1'b0;
      char_xy = addr;
      cycle();
      chk("read_cell", int'(char_code), int'(exp));
   endtask

   initial begin
      int n, r;
      tbl[0]  = '{CMD_PUT,        8'h41, 8'h01};
      tbl[1]  = '{CMD_PUT,        8'h42, 8'h02};
      tbl[2]  = '{CMD_SET_CURSOR, 8'h0F, 8'h0F};
      tbl[3]  = '{CMD_PUT,        8'h43, 8'h10};
      tbl[4]  = '{CMD_SET_CURSOR, 8'hFF, 8'hFF};
      tbl[5]  = '{CMD_PUT,        8'h44, 8'h00};
      tbl[6]  = '{CMD_SET_CURSOR, 8'h35, 8'h35};
      tbl[7]  = '{CMD_NEWLINE,    8'h00, 8'h40};
      tbl[8]  = '{CMD_SET_CURSOR, 8'hF7, 8'hF7};
      tbl[9]  = '{CMD_NEWLINE,    8'h99, 8'h00};
      tbl[10] = '{CMD_SET_CURSOR, 8'h1A, 8'h1A};
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         cmd(tbl[i].op, tbl[i].data);
         chk("tbl_cursor", int'(cursor_xy), int'(tbl[i].exp_cur));
      end
      rd(8'h00, 7'h41);
      rd(8'h01, 7'h42);
      rd(8'h0F, 7'h43);
      rd(8'hFF, 7'h44);
      // CLEAR with a PUT held on the interface for the whole sweep
      cmd(CMD_CLEAR, 8'h00);
      cmd_valid = 1'b1;
      cmd_op = CMD_PUT;
      cmd_data = 8'h58;
      n = 0;
      do begin
         cycle();
         if (last_busy) n++;
      end while (last_busy && n < 300);
      cmd_valid = 1'b0;
      chk("clear_busy_cycles", n, 256);
      chk("held_put_accepted", int'(last_acc), 1);
      rd(8'h00, 7'h58);
      rd(8'h01, BLANK);
      rd(8'h80, BLANK);
      rd(8'hFF, BLANK);
      // same-cycle read and PUT of cell 0 returns the old code first
      cmd(CMD_CLEAR, 8'h00);
      repeat (256) cycle();
      char_xy = 8'h00;
      cmd(CMD_PUT, 8'h41);
      chk("read_first_old", int'(char_code), int'(BLANK));
      rd(8'h00, 7'h41);
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         cmd_valid = $urandom_range(0, 3) != 0;
         cmd_op = r < 50 ? CMD_PUT : r < 65 ? CMD_NEWLINE : r < 98 ? CMD_SET_CURSOR : CMD_CLEAR;
         cmd_data = 8'($urandom);
         char_xy = 8'($urandom);
         cycle();
      end
      cmd_valid = 1'b0;
      while (m_clr > 0) cycle();
      // fill every cell, then abort a CLEAR after 100 sweep cycles
      cmd(CMD_SET_CURSOR, 8'h00);
      for (int i = 0; i < 256; i++) cmd(CMD_PUT, 8'($urandom_range(0, 127)));
      cmd(CMD_CLEAR, 8'h00);
      repeat (100) cycle();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         char_xy = 8'(i);
         cycle();
      end
      rd(8'h63, BLANK);
      rd(8'h00, BLANK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
